// File: rtl/vscpu_boot_loader_pkg.sv
// Shared definitions for the VSCPU boot loader: state encoding, frame
// field positions and widths, and the length-range helper.
package vscpu_boot_loader_pkg;

    localparam int unsigned ADDR_W_DEFAULT = 14;
    localparam int unsigned DATA_W         = 32;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned LEN_W          = 16;
    localparam int unsigned BCNT_W         = 2;

    // Bit positions of the two length bytes inside the 16-bit word count
    localparam int unsigned LEN_HI_LSB = 8;
    localparam int unsigned LEN_LO_LSB = 0;

    // Byte counter value of the last (least significant) byte of a word
    localparam logic [BCNT_W-1:0] LAST_WORD_BYTE = BCNT_W'(3);

    typedef enum logic [2:0] {
        ST_LEN_HI = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_WORD   = 3'd2,
        ST_WRITE  = 3'd3,
        ST_CHK    = 3'd4,
        ST_RUN    = 3'd5,
        ST_ERR    = 3'd6
    } state_t;

    // A word count fits when no bit at or above the RAM address width is set
    function automatic logic len_fits(input logic [LEN_W-1:0] len,
                                      input int unsigned      addr_w);
        return (32'(len) >> addr_w) == 32'd0;
    endfunction

endpackage

// File: rtl/vscpu_boot_loader_ram_port_mux.sv
// RAM write-port selector: the loader owns the port during loading,
// the CPU owns it once the image is running.
// Ports:
//   sel_cpu              1 = CPU drives the RAM port
//   ldr_we/addr/din      loader write request
//   cpu_we/addr/din      CPU write request
//   ram_we/addr/din      to the block RAM
module vscpu_ram_port_mux
    import vscpu_boot_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              sel_cpu,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_din,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_din,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din
);

    assign ram_we   = sel_cpu ? cpu_we   : ldr_we;
    assign ram_addr = sel_cpu ? cpu_addr : ldr_addr;
    assign ram_din  = sel_cpu ? cpu_din  : ldr_din;

endmodule

// File: rtl/vscpu_boot_loader.sv
// Program-load stage ahead of the VSCPU block RAM. Holds the CPU in reset,
// receives a framed image (LEN_HI, LEN_LO, N big-endian words, XOR CHK),
// writes it to RAM from BASE_ADDR, then hands the RAM port to the CPU.
// Ports:
//   clk, rst                 clock, async active-low reset
//   in_valid/in_data/in_ready host byte stream (transfer on valid & ready)
//   reload                   restart a load from RUN or ERR
//   cpu_wrEn/addr/data       CPU write port, used only while running
//   ram_we/addr/din          RAM write port
//   cpu_rst                  active-high CPU reset
//   busy, done, err          load status (err sticky until reload/rst)
module vscpu_boot_loader
    import vscpu_boot_loader_pkg::*;
#(
    parameter int unsigned ADDR_W    = ADDR_W_DEFAULT,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    output logic              in_ready,
    input  logic              reload,
    input  logic              cpu_wrEn,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_data,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_t state, next_state;

    logic                     xfer;
    logic                     len_hi_ld, len_lo_ld, byte_ld, word_wr, restart;
    logic [LEN_W-1:0]         len_q, len_rx, idx_q, idx_inc;
    logic [BCNT_W-1:0]        bcnt_q;
    logic [DATA_W-BYTE_W-1:0] word_q;
    logic [DATA_W-1:0]        word_rx;
    logic [BYTE_W-1:0]        xor_q;

    logic                     ldr_we_q;
    logic [ADDR_W-1:0]        ldr_addr_q;
    logic [DATA_W-1:0]        ldr_din_q;
    logic                     in_ready_q, busy_q, done_q, err_q, cpu_rst_q;

    assign xfer    = in_valid & in_ready_q;
    // Full word count as it will look once the low byte lands
    assign len_rx  = {len_q[LEN_HI_LSB +: BYTE_W], in_data};
    assign idx_inc = idx_q + LEN_W'(1);
    // Word as it will look once the current byte is shifted in
    assign word_rx = {word_q, in_data};

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_LEN_HI;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and datapath strobes
    always_comb begin
        next_state = state;
        len_hi_ld  = 1'b0;
        len_lo_ld  = 1'b0;
        byte_ld    = 1'b0;
        word_wr    = 1'b0;
        restart    = 1'b0;
        case (state)
            ST_LEN_HI: begin
                if (xfer) begin
                    len_hi_ld  = 1'b1;
                    next_state = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (xfer) begin
                    len_lo_ld = 1'b1;
                    if (!len_fits(len_rx, ADDR_W)) begin
                        next_state = ST_ERR;
                    end else if (len_rx == '0) begin
                        next_state = ST_CHK;
                    end else begin
                        next_state = ST_WORD;
                    end
                end
            end
            ST_WORD: begin
                if (xfer) begin
                    byte_ld = 1'b1;
                    if (bcnt_q == LAST_WORD_BYTE) begin
                        next_state = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                word_wr    = 1'b1;
                next_state = (idx_inc == len_q) ? ST_CHK : ST_WORD;
            end
            ST_CHK: begin
                if (xfer) begin
                    next_state = (in_data == xor_q) ? ST_RUN : ST_ERR;
                end
            end
            ST_RUN, ST_ERR: begin
                if (reload) begin
                    restart    = 1'b1;
                    next_state = ST_LEN_HI;
                end
            end
            default: next_state = ST_LEN_HI;
        endcase
    end

    // Frame datapath: length, word index, byte counter, shift register, XOR
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_q  <= '0;
            idx_q  <= '0;
            bcnt_q <= '0;
            word_q <= '0;
            xor_q  <= '0;
        end else if (restart) begin
            len_q  <= '0;
            idx_q  <= '0;
            bcnt_q <= '0;
            word_q <= '0;
            xor_q  <= '0;
        end else begin
            if (len_hi_ld || len_lo_ld || byte_ld) begin
                xor_q <= xor_q ^ in_data;
            end
            if (len_hi_ld) begin
                len_q[LEN_HI_LSB +: BYTE_W] <= in_data;
            end
            if (len_lo_ld) begin
                len_q[LEN_LO_LSB +: BYTE_W] <= in_data;
            end
            if (byte_ld) begin
                word_q <= word_rx[DATA_W-BYTE_W-1:0];
                bcnt_q <= bcnt_q + BCNT_W'(1);
            end
            if (word_wr) begin
                idx_q <= idx_inc;
            end
        end
    end

    // Loader write request, presented during the single WRITE cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ldr_we_q   <= 1'b0;
            ldr_addr_q <= '0;
            ldr_din_q  <= '0;
        end else begin
            ldr_we_q <= (next_state == ST_WRITE);
            if (next_state == ST_WRITE) begin
                ldr_addr_q <= ADDR_W'(BASE_ADDR) + ADDR_W'(idx_q);
                ldr_din_q  <= word_rx;
            end
        end
    end

    // Status outputs registered from the next state so they track it exactly
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cpu_rst_q  <= 1'b1;
        end else begin
            in_ready_q <= next_state inside {ST_LEN_HI, ST_LEN_LO, ST_WORD, ST_CHK};
            busy_q     <= !(next_state inside {ST_RUN, ST_ERR});
            done_q     <= (next_state == ST_RUN);
            err_q      <= (next_state == ST_ERR);
            cpu_rst_q  <= (next_state != ST_RUN);
        end
    end

    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign cpu_rst  = cpu_rst_q;

    vscpu_ram_port_mux #(
        .ADDR_W (ADDR_W)
    ) u_ram_port_mux (
        .sel_cpu  (state == ST_RUN),
        .ldr_we   (ldr_we_q),
        .ldr_addr (ldr_addr_q),
        .ldr_din  (ldr_din_q),
        .cpu_we   (cpu_wrEn),
        .cpu_addr (cpu_addr),
        .cpu_din  (cpu_data),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_din  (ram_din)
    );

endmodule

// File: tb/tb_vscpu_boot_loader.sv
// Self-checking bench for vscpu_boot_loader: a table of frames with
// hand-computed checksums and outcomes, plus directed sequences for
// stalled input, reload during load, mid-load reset and CPU pass-through.
module tb_vscpu_boot_loader;

    localparam int unsigned AW = 14;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          reload;
    logic          cpu_wrEn;
    logic [AW-1:0] cpu_addr;
    logic [31:0]   cpu_data;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_din;
    logic          cpu_rst;
    logic          busy;
    logic          done;
    logic          err;

    always #5 clk = ~clk;

    vscpu_boot_loader #(
        .ADDR_W    (AW),
        .BASE_ADDR (0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .reload   (reload),
        .cpu_wrEn (cpu_wrEn),
        .cpu_addr (cpu_addr),
        .cpu_data (cpu_data),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .cpu_rst  (cpu_rst),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    typedef struct {
        logic [15:0] len;
        bit          body;
        int          nwords;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [7:0]  chk;
        bit          exp_done;
        bit          exp_err;
        int          exp_writes;
    } vec_t;

    vec_t vecs [5];

    int total = 0;
    int bad   = 0;

    // RAM model and loader-write log
    int            cyc = 0;
    logic [31:0]   mem [int];
    logic [AW-1:0] wr_addr [$];
    logic [31:0]   wr_data [$];
    int            wr_cyc  [$];
    int            dup_cnt = 0;
    logic          prev_we = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (ram_we) mem[int'(ram_addr)] = ram_din;
        if (ram_we && cpu_rst) begin
            wr_addr.push_back(ram_addr);
            wr_data.push_back(ram_din);
            wr_cyc.push_back(cyc);
        end
        if (ram_we && prev_we && cpu_rst) dup_cnt++;
        prev_we = ram_we;
    end

    function automatic logic [31:0] mem_rd(input int a);
        if (mem.exists(a)) return mem[a];
        return 32'hxxxx_xxxx;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
    endtask

    // Offer one byte after 'gap' idle cycles; returns #1 after the transfer edge
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        ok = 1'b0;
        repeat (gap) @(negedge clk);
        for (int n = 0; n < 64 && !ok; n++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = b;
            if (in_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end
        end
        in_valid = 1'b0;
        in_data  = 8'h5A;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL send_byte: byte 0x%0h never accepted (t=%0t)", b, $time);
        end
    endtask

    task automatic send_frame(input vec_t v, input int gap);
        logic [31:0] word;
        send_byte(v.len[15:8], gap);
        send_byte(v.len[7:0], gap);
        if (v.body) begin
            for (int w = 0; w < v.nwords; w++) begin
                word = (w == 0) ? v.w0 : v.w1;
                for (int k = 3; k >= 0; k--) send_byte(word[k*8 +: 8], gap);
                check("wr_latency", 32'(ram_we), 32'd1);
            end
            send_byte(v.chk, gap);
        end
    endtask

    task automatic pulse_reload();
        @(negedge clk);
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
    endtask

    task automatic check_reloaded(input string tag);
        check({tag, "_busy"},    32'(busy),    32'd1);
        check({tag, "_err"},     32'(err),     32'd0);
        check({tag, "_done"},    32'(done),    32'd0);
        check({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [7:0] tog_bytes  [11];
    logic [7:0] part_bytes [10];

    initial begin
        in_valid = 1'b0;
        in_data  = 8'h00;
        reload   = 1'b0;
        cpu_wrEn = 1'b1;
        cpu_addr = 14'h3FFF;
        cpu_data = 32'hDEAD_BEEF;

        // len, body, nwords, w0, w1, chk, exp_done, exp_err, exp_writes
        vecs[0] = '{16'h0002, 1'b1, 2, 32'h9000_4005, 32'h1234_ABCD, 8'h97, 1'b1, 1'b0, 2};
        vecs[1] = '{16'h0002, 1'b1, 2, 32'h9000_4005, 32'h1234_ABCD, 8'h96, 1'b0, 1'b1, 2};
        vecs[2] = '{16'h0000, 1'b1, 0, 32'h0,         32'h0,         8'h00, 1'b1, 1'b0, 0};
        vecs[3] = '{16'h4001, 1'b0, 0, 32'h0,         32'h0,         8'h00, 1'b0, 1'b1, 0};
        vecs[4] = '{16'h0001, 1'b1, 1, 32'h1122_3344, 32'h0,         8'h45, 1'b1, 1'b0, 1};

        tog_bytes  = '{8'h00, 8'h02, 8'h90, 8'h00, 8'h40, 8'h05,
                       8'h12, 8'h34, 8'hAB, 8'hCD, 8'h97};
        part_bytes = '{8'h00, 8'h03, 8'hCA, 8'hFE, 8'h00, 8'h01,
                       8'hBE, 8'hEF, 8'h00, 8'h02};

        // Reset values, with CPU write enable asserted and ignored
        repeat (3) @(negedge clk);
        check("rst_cpu_rst",  32'(cpu_rst),  32'd1);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_done",     32'(done),     32'd0);
        check("rst_err",      32'(err),      32'd0);
        check("rst_ram_we",   32'(ram_we),   32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        check("post_rst_busy",     32'(busy),     32'd1);

        // Table-driven frames
        for (int i = 0; i < 5; i++) begin
            clear_log();
            send_frame(vecs[i], 0);
            check($sformatf("v%0d_done", i),     32'(done),     32'(vecs[i].exp_done));
            check($sformatf("v%0d_err", i),      32'(err),      32'(vecs[i].exp_err));
            check($sformatf("v%0d_cpu_rst", i),  32'(cpu_rst),  32'(!vecs[i].exp_done));
            check($sformatf("v%0d_busy", i),     32'(busy),     32'd0);
            check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd0);
            repeat (3) @(negedge clk);
            check($sformatf("v%0d_nwrites", i), 32'(wr_addr.size()), 32'(vecs[i].exp_writes));
            for (int j = 0; j < vecs[i].exp_writes && j < wr_addr.size(); j++) begin
                check($sformatf("v%0d_addr%0d", i, j), 32'(wr_addr[j]), 32'(j));
                check($sformatf("v%0d_data%0d", i, j), wr_data[j],
                      (j == 0) ? vecs[i].w0 : vecs[i].w1);
            end
            if (vecs[i].exp_writes == 2 && wr_cyc.size() == 2)
                check($sformatf("v%0d_wr_spacing", i), 32'(wr_cyc[1] - wr_cyc[0]), 32'd5);
            pulse_reload();
            check_reloaded($sformatf("v%0d_reload", i));
        end

        // Stalled input every other cycle; reload pulse in LEN_LO must be ignored
        clear_log();
        for (int i = 0; i < 11; i++) begin
            send_byte(tog_bytes[i], 1);
            if (i == 0) begin
                pulse_reload();
                check("tog_reload_ignored_busy", 32'(busy), 32'd1);
            end
        end
        check("tog_done",    32'(done),    32'd1);
        check("tog_cpu_rst", 32'(cpu_rst), 32'd0);
        repeat (3) @(negedge clk);
        check("tog_nwrites", 32'(wr_addr.size()), 32'd2);
        if (wr_addr.size() == 2) begin
            check("tog_addr0", 32'(wr_addr[0]), 32'd0);
            check("tog_data0", wr_data[0], 32'h9000_4005);
            check("tog_addr1", 32'(wr_addr[1]), 32'd1);
            check("tog_data1", wr_data[1], 32'h1234_ABCD);
            check("tog_wr_spacing", 32'(wr_cyc[1] - wr_cyc[0]), 32'd8);
        end
        pulse_reload();
        check_reloaded("tog_reload");

        // Reset asserted right after the second word of a 3-word frame is written
        clear_log();
        for (int i = 0; i < 10; i++) send_byte(part_bytes[i], 0);
        check("part_second_write", 32'(ram_we), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("abort_cpu_rst",  32'(cpu_rst),  32'd1);
        check("abort_in_ready", 32'(in_ready), 32'd0);
        check("abort_busy",     32'(busy),     32'd0);
        check("abort_done",     32'(done),     32'd0);
        check("abort_err",      32'(err),      32'd0);
        check("abort_ram_we",   32'(ram_we),   32'd0);
        check("abort_mem0_kept", mem_rd(0), 32'hCAFE_0001);
        check("abort_mem1_kept", mem_rd(1), 32'hBEEF_0002);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Fresh frame after the abort, then CPU pass-through in RUN
        clear_log();
        send_frame(vecs[0], 0);
        check("reload_frame_done",    32'(done),    32'd1);
        check("reload_frame_cpu_rst", 32'(cpu_rst), 32'd0);
        repeat (2) @(negedge clk);
        check("reload_frame_mem0", mem_rd(0), 32'h9000_4005);
        check("reload_frame_mem1", mem_rd(1), 32'h1234_ABCD);
        check("reload_frame_nwrites", 32'(wr_addr.size()), 32'd2);
        cpu_wrEn = 1'b1;
        cpu_addr = 14'h0005;
        cpu_data = 32'd7;
        #1;
        check("pass_we",   32'(ram_we),   32'd1);
        check("pass_addr", 32'(ram_addr), 32'h0005);
        check("pass_din",  ram_din,       32'd7);
        cpu_wrEn = 1'b0;
        #1;
        check("pass_we_low", 32'(ram_we), 32'd0);

        check("no_back_to_back_we", 32'(dup_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vscpu_boot_loader.md
Name: vscpu_boot_loader

Overview:
Program-load stage between the host byte stream and the 14-bit-address, 32-bit-data block RAM that serves the VSCPU core. After reset it holds the CPU in reset, owns the RAM write port, and writes a framed image of N words starting at a base address. On a good checksum it hands the RAM port to the CPU and releases CPU reset. The block sits directly upstream of the CPU on the RAM write path; data_fromRAM goes straight from RAM to the CPU and bypasses this block.

Parameters:
ADDR_W, 14, RAM address width (matches CPU addr_toRAM)
BASE_ADDR, 0, RAM address of the first loaded word (CPU PC resets to 0)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
in_valid  in  1  host byte valid
in_data  in  8  host byte
in_ready  out  1  loader accepts byte; transfer when in_valid&in_ready
reload  in  1  synchronous pulse; restarts load from RUN or ERR
cpu_wrEn  in  1  CPU write enable
cpu_addr  in  ADDR_W  CPU RAM address
cpu_data  in  32  CPU write data
ram_we  out  1  to RAM we
ram_addr  out  ADDR_W  to RAM addr
ram_din  out  32  to RAM din
cpu_rst  out  1  active-high reset to CPU
busy  out  1  load in progress
done  out  1  image loaded, CPU running
err  out  1  framing or checksum error; sticky until reload/rst

Behaviour:
- Frame: LEN_HI, LEN_LO (16-bit word count N, big-endian), N×4 payload bytes (big-endian words), then CHK byte. CHK = XOR of every byte from LEN_HI through the last payload byte.
- States: LEN_HI, LEN_LO, WORD, WRITE, CHK, RUN, ERR.
- Reset (rst=0, async): state=LEN_HI, cpu_rst=1, ram_we=0, in_ready=0, busy=0, done=0, err=0, counters and XOR cleared. First cycle after release: in_ready=1, busy=1.
- LEN_HI and LEN_LO: accept one byte each. After LEN_LO, if N[15:ADDR_W]!=0, go to ERR. If N==0, go to CHK. Otherwise go to WORD with word index 0.
- WORD: shift in bytes MSB first, counting 0..3. When the 4th byte is accepted, go to WRITE.
- WRITE: exactly one cycle. in_ready=0, ram_we=1, ram_addr=BASE_ADDR+index (mod 2^ADDR_W, wraps), ram_din=assembled word. Then index++. If index==N, go to CHK; otherwise go to WORD.
- Write latency: one cycle from acceptance of the 4th byte to ram_we.
- Throughput: one word per 5 cycles at full in_valid.
- CHK: accept one byte. If it matches the XOR, go to RUN; otherwise go to ERR.
- RUN: cpu_rst=0, done=1, busy=0, in_ready=0. RAM port passes through combinationally: ram_we=cpu_wrEn, ram_addr=cpu_addr, ram_din=cpu_data.
- In every state other than RUN: cpu_rst=1, and CPU port inputs are ignored (ram_we is driven only by the loader).
- ERR: err=1, busy=0, in_ready=0, cpu_rst=1, ram_we=0.
- reload=1 in RUN or ERR: next state LEN_HI; clear err, done, XOR, counters; cpu_rst=1 from that same edge. reload is ignored in all load states.
- in_valid=0 stalls any state with no side effects. in_data is sampled only on transfer.
- rst asserted mid-load: immediate abort. Words already written stay in RAM; the load restarts from LEN_HI.
- ram_we never asserts in two consecutive cycles during a load.

Decomposition:
- Shared package: state encoding enum, LEN/CHK byte-position constants, ADDR_W default.
- One natural sub-module: vscpu_ram_port_mux (2:1 mux of we/addr/din, select = RUN). Everything else stays inline in a single FSM always block plus registered datapath.

Test Plan:
- Load N=2, words 0x9000_4005, 0x1234_ABCD, correct CHK -> ram_we pulses at addr 0 then 1 with those values; done=1, cpu_rst=0 one cycle after CHK transfer.
- Same frame, CHK byte XOR 0x01 -> err=1, done=0, cpu_rst stays 1, no further ram_we; reload pulse -> busy=1, err=0.
- N=0 frame (00 00 00) -> no ram_we, RUN reached after 3 transfers.
- in_valid toggled 1/0 every cycle during payload -> identical RAM contents, write cycles delayed, no duplicate writes.
- Length 0x4001 -> ERR immediately after LEN_LO transfer, no RAM write.
- rst low for 1 cycle after 2nd payload word write -> outputs at reset values immediately; a fresh full frame then loads correctly, and in RUN cpu_wrEn=1, cpu_addr=0x0005, cpu_data=7 appear on ram_* the same cycle.
